// File: rtl/rx_frame_pkg.sv
// Shared types and default constants for the RX frame writer and its descriptor FIFO.
package rx_frame_pkg;

  localparam int unsigned DefAddrW       = 14;
  localparam int unsigned DefMaxFrameLen = 1536;

  typedef logic [1:0] rx_state_e;
  localparam rx_state_e StIdle   = 2'd0;
  localparam rx_state_e StWrite  = 2'd1;
  localparam rx_state_e StDrop   = 2'd2;
  localparam rx_state_e StCommit = 2'd3;

  typedef struct packed {
    logic [DefAddrW-1:0] start;
    logic [DefAddrW-1:0] len;
  } rx_desc_t;

endpackage

// File: rtl/rx_desc_fifo.sv
// First-word fall-through descriptor FIFO; pointers carry an extra wrap bit for full/empty.
module rx_desc_fifo
  import rx_frame_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  rx_desc_t din_i,
  input  logic     pop_i,
  output rx_desc_t dout_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  rx_desc_t      mem_q [Depth];
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign dout_o  = mem_q[rptr_q[PtrW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= din_i;
  end

endmodule

// File: rtl/rx_frame_writer.sv
// Writes a byte stream frame-by-frame into a circular buffer and publishes {start, len}
// descriptors; frames that cannot be stored whole are rolled back and counted as drops.
module rx_frame_writer
  import rx_frame_pkg::*;
#(
  parameter int unsigned ADDR_W        = DefAddrW,
  parameter int unsigned MAX_FRAME_LEN = DefMaxFrameLen,
  parameter int unsigned DESC_DEPTH    = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_din_o,
  input  logic [ADDR_W-1:0] rd_ptr_i,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_start_o,
  output logic [ADDR_W-1:0] desc_len_o,
  output logic              drop_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam logic [ADDR_W-1:0] MaxLen = ADDR_W'(MAX_FRAME_LEN);

  rx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              accept;
  logic [ADDR_W-1:0] free;
  logic              no_space;
  logic              fifo_push, fifo_full, fifo_empty;
  rx_desc_t          fifo_din, fifo_dout;

  assign s_ready_o = (state_q != StCommit);
  assign accept    = s_valid_i & s_ready_o;
  // One slot stays empty so wr_ptr == rd_ptr_i unambiguously means empty.
  assign free      = rd_ptr_i - wr_ptr_q - ADDR_W'(1);
  assign no_space  = (free == '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    start_d    = start_q;
    len_d      = len_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    drop_d     = 1'b0;
    fifo_push  = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (fifo_full || no_space) begin
            if (s_last_i) drop_d  = 1'b1;
            else          state_d = StDrop;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = wr_ptr_q;
            mem_din_d  = s_data_i;
            start_d    = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            len_d      = ADDR_W'(1);
            state_d    = s_last_i ? StCommit : StWrite;
          end
        end
      end
      StWrite: begin
        if (accept) begin
          if (no_space || (len_q == MaxLen)) begin
            wr_ptr_d = start_q;
            if (s_last_i) begin
              drop_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StDrop;
            end
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = wr_ptr_q;
            mem_din_d  = s_data_i;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            len_d      = len_q + ADDR_W'(1);
            if (s_last_i) state_d = StCommit;
          end
        end
      end
      StDrop: begin
        if (accept && s_last_i) begin
          drop_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StCommit: begin
        // Last byte is written this cycle, so the descriptor surfaces a cycle later.
        fifo_push = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      start_q    <= '0;
      len_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      start_q    <= start_d;
      len_q      <= len_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fifo_din.start = start_q;
  assign fifo_din.len   = len_q;

  rx_desc_fifo #(
    .Depth(DESC_DEPTH)
  ) u_desc_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (fifo_push),
    .din_i  (fifo_din),
    .pop_i  (desc_ready_i),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_en_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_din_o    = mem_din_q;
  assign desc_valid_o = ~fifo_empty;
  assign desc_start_o = fifo_dout.start;
  assign desc_len_o   = fifo_dout.len;
  assign drop_o       = drop_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_writer.sv
// Scoreboard bench for rx_frame_writer: directed frames push expected RAM writes,
// descriptors and drop pulses; a monitor pops and compares as the DUT emits them.
module tb_rx_frame_writer;

  logic        clk;
  logic        rst_ni;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [13:0] mem_addr_o;
  logic [7:0]  mem_din_o;
  logic [13:0] rd_ptr_i;
  logic        desc_valid_o;
  logic        desc_ready_i;
  logic [13:0] desc_start_o;
  logic [13:0] desc_len_o;
  logic        drop_o;
  logic [15:0] drop_cnt_o;

  rx_frame_writer #(
    .ADDR_W       (14),
    .MAX_FRAME_LEN(1536),
    .DESC_DEPTH   (4),
    .CNT_W        (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_din_o   (mem_din_o),
    .rd_ptr_i    (rd_ptr_i),
    .desc_valid_o(desc_valid_o),
    .desc_ready_i(desc_ready_i),
    .desc_start_o(desc_start_o),
    .desc_len_o  (desc_len_o),
    .drop_o      (drop_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data; int cyc;} wr_t;
  typedef struct {int start; int len; int cyc;} desc_t;
  typedef struct {int cnt; int cyc;} drop_t;

  wr_t   wq[$];
  desc_t dq[$];
  drop_t pq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  // Monitor: every DUT output event is matched against the head of its queue.
  initial begin
    wr_t   ew;
    desc_t ed;
    drop_t ep;
    forever begin
      @(negedge clk);
      if (mem_en_o) begin
        if (wq.size() == 0) begin
          check(1'b0, "wr_unexpected", $sformatf("got addr %0d data %02h, expected no write",
                mem_addr_o, mem_din_o));
        end else begin
          ew = wq.pop_front();
          check(mem_we_o && int'(mem_addr_o) == ew.addr && int'(mem_din_o) == ew.data &&
                cyc == ew.cyc, "wr",
                $sformatf("got we %0b addr %0d data %02h cyc %0d, expected addr %0d data %02h cyc %0d",
                mem_we_o, mem_addr_o, mem_din_o, cyc, ew.addr, ew.data, ew.cyc));
        end
      end
      if (desc_valid_o && desc_ready_i) begin
        if (dq.size() == 0) begin
          check(1'b0, "desc_unexpected", $sformatf("got start %0d len %0d, expected none",
                desc_start_o, desc_len_o));
        end else begin
          ed = dq.pop_front();
          check(int'(desc_start_o) == ed.start && int'(desc_len_o) == ed.len &&
                (ed.cyc < 0 || cyc == ed.cyc), "desc",
                $sformatf("got start %0d len %0d cyc %0d, expected start %0d len %0d cyc %0d",
                desc_start_o, desc_len_o, cyc, ed.start, ed.len, ed.cyc));
        end
      end
      if (drop_o) begin
        if (pq.size() == 0) begin
          check(1'b0, "drop_unexpected", $sformatf("got drop cnt %0d, expected none", drop_cnt_o));
        end else begin
          ep = pq.pop_front();
          check(int'(drop_cnt_o) == ep.cnt && cyc == ep.cyc, "drop",
                $sformatf("got cnt %0d cyc %0d, expected cnt %0d cyc %0d",
                drop_cnt_o, cyc, ep.cnt, ep.cyc));
        end
      end
    end
  end

  // Drive one byte and return the cycle it was accepted in; ok=0 if ready never came.
  task automatic send_byte(input logic [7:0] d, input logic last, output int acc, output bit ok);
    s_data_i  = d;
    s_valid_i = 1'b1;
    s_last_i  = last;
    ok        = 1'b0;
    acc       = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check(1'b0, "ready_timeout", "got s_ready_o stuck low, expected 1 within 100 cycles");
    end else begin
      acc = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  // n bytes of data d0+i; the first nwr land at start+i; desc/drop expectations as given.
  task automatic send_frame(input int n, input int d0, input int start, input int nwr,
                            input bit exp_desc, input bit chk_cyc, input int drop_cnt);
    int acc;
    bit ok;
    acc = -1;
    for (int i = 0; i < n; i++) begin
      send_byte(8'((d0 + i) % 256), (i == n - 1), acc, ok);
      if (!ok) begin
        s_valid_i = 1'b0;
        return;
      end
      if (i < nwr) wq.push_back('{(start + i) % 16384, (d0 + i) % 256, acc + 1});
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    if (exp_desc) dq.push_back('{start, nwr, chk_cyc ? acc + 2 : -1});
    if (drop_cnt >= 0) pq.push_back('{drop_cnt, acc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no end of test, expected completion within 3 ms");
    $fatal(1, "timeout");
  end

  initial begin
    int addr;
    int len;
    int acc;
    bit ok;

    rst_ni       = 1'b0;
    s_data_i     = '0;
    s_valid_i    = 1'b0;
    s_last_i     = 1'b0;
    rd_ptr_i     = '0;
    desc_ready_i = 1'b1;
    idle(3);
    check(!mem_en_o && !mem_we_o && mem_addr_o == 0 && mem_din_o == 0, "reset_mem",
          $sformatf("got en %0b we %0b addr %0d din %0d, expected all 0",
          mem_en_o, mem_we_o, mem_addr_o, mem_din_o));
    check(!desc_valid_o && !drop_o && drop_cnt_o == 0, "reset_status",
          $sformatf("got desc_valid %0b drop %0b cnt %0d, expected 0 0 0",
          desc_valid_o, drop_o, drop_cnt_o));
    rst_ni = 1'b1;
    idle(1);
    check(s_ready_o == 1'b1, "ready_idle", $sformatf("got %0b, expected 1", s_ready_o));

    // Basic 4-byte frame at address 0.
    send_frame(4, 'hA1, 0, 4, 1'b1, 1'b1, -1);
    idle(4);
    send_frame(1, 'hB0, 4, 1, 1'b1, 1'b1, -1);
    idle(4);

    // Buffer fills after 4 bytes: rollback to 5 and one drop.
    rd_ptr_i = 14'd10;
    send_frame(10, 'hD0, 5, 4, 1'b0, 1'b0, 1);
    idle(4);

    // Descriptor FIFO fills; fifth frame dropped without any RAM write.
    desc_ready_i = 1'b0;
    rd_ptr_i     = 14'd200;
    for (int k = 0; k < 4; k++) send_frame(1, 'hC0 + k, 5 + k, 1, 1'b1, 1'b0, -1);
    send_frame(1, 'hCF, 9, 0, 1'b0, 1'b0, 2);
    idle(3);
    check(desc_valid_o == 1'b1, "fifo_full_valid", $sformatf("got %0b, expected 1", desc_valid_o));
    desc_ready_i = 1'b1;
    idle(8);
    check(desc_valid_o == 1'b0, "fifo_drained", $sformatf("got %0b, expected 0", desc_valid_o));

    // Over-length frame: 1536 bytes written, then rollback; next frame reuses the start.
    rd_ptr_i = 14'd9;
    send_frame(1537, 0, 9, 1536, 1'b0, 1'b0, 3);
    idle(3);
    send_frame(1, 'h77, 9, 1, 1'b1, 1'b1, -1);
    idle(3);

    // Advance the write pointer to 16380 with full-size frames.
    addr = 10;
    while (addr != 16380) begin
      len      = (16380 - addr > 1536) ? 1536 : 16380 - addr;
      rd_ptr_i = 14'(addr);
      send_frame(len, 0, addr, len, 1'b1, 1'b1, -1);
      addr += len;
    end
    idle(3);

    // Frame straddling the top of the buffer.
    rd_ptr_i = 14'd16380;
    send_frame(8, 'hE0, 16380, 8, 1'b1, 1'b1, -1);
    idle(4);

    // Reset after three bytes of a frame at address 4; only the first two writes appear.
    for (int i = 0; i < 3; i++) begin
      send_byte(8'('hF0 + i), 1'b0, acc, ok);
      if (ok && i < 2) wq.push_back('{4 + i, 'hF0 + i, acc + 1});
    end
    rst_ni    = 1'b0;
    s_valid_i = 1'b0;
    #1;
    check(!mem_en_o && !mem_we_o && !desc_valid_o && !drop_o && drop_cnt_o == 0, "midframe_reset",
          $sformatf("got en %0b we %0b desc_valid %0b drop %0b cnt %0d, expected all 0",
          mem_en_o, mem_we_o, desc_valid_o, drop_o, drop_cnt_o));
    idle(2);
    rst_ni   = 1'b1;
    rd_ptr_i = '0;
    idle(1);
    send_frame(1, 'h5A, 0, 1, 1'b1, 1'b1, -1);
    idle(6);

    check(wq.size() == 0, "wr_left", $sformatf("got %0d pending writes, expected 0", wq.size()));
    check(dq.size() == 0, "desc_left", $sformatf("got %0d pending descs, expected 0", dq.size()));
    check(pq.size() == 0, "drop_left", $sformatf("got %0d pending drops, expected 0", pq.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
